fp_sub_seq: RTL and testbench
=============================

Name: fp_sub_seq

Overview:
Multi-cycle FP32 subtractor computing out = inputA - inputB. It is the inverse-operation companion to the combinational FP32 adder and uses the same operand semantics: zero bypass, truncation, no rounding, no IEEE special-case handling. It is iterative: one alignment shift per cycle, then one add cycle, then one normalisation shift per cycle. Operands are taken and results returned over valid/ready handshakes, so the block drops into the TPU accumulate path where area matters more than latency.

Parameters:
SHIFT_CAP, 24, maximum number of alignment shift cycles. Once the exponent difference reaches this cap, the smaller mantissa is already zero.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
inputA  input  32  FP32 minuend {sign, exp[7:0], man[22:0]}
inputB  input  32  FP32 subtrahend
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  32  FP32 difference

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; out_valid=0; out=32'h0; all internal registers cleared.
  - in_ready=0 while rst=1; in_ready=1 in IDLE afterwards.
  - Reset mid-operation abandons the in-flight operation; no result is produced.
- in_ready = (state==IDLE) && !rst. Accept occurs on a clk edge with in_valid&&in_ready.
  - inputA/inputB are sampled only at accept; later input changes are ignored.
- Operand prep at accept:
  - B is treated with its sign bit inverted (sB' = ~inputB[31]).
  - Mantissas are {1, man[22:0]} (24 bit).
  - The larger operand is the one with the larger unsigned biased exponent. On a tie it is A.
  - d = larger exponent - smaller exponent (8-bit unsigned); cnt = min(d, SHIFT_CAP).
  - Result exponent register = larger biased exponent.
- Zero bypass (checked at accept, first match wins):
  - inputA==32'h0 -> result {~inputB[31], inputB[30:0]}.
  - Else inputB==32'h0 -> result inputA.
  - Next state is DONE.
  - Note: 0 - 0 gives 32'h80000000, i.e. the sign flip of the first rule.
- States: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
  - ALIGN: each cycle, if cnt!=0, shift the smaller mantissa right 1 (LSB discarded) and decrement cnt; else go to ADD. Occupancy is cnt+1 cycles.
  - ADD, 1 cycle, 25-bit arithmetic:
    - Equal signs: sum = Ml + Ms, sign = common sign.
    - Different signs: if Ms < Ml, sum = Ml - Ms with the larger operand's sign; else sum = Ms - Ml with the smaller operand's sign.
    - If sum[24]=1: shift right 1 (truncate) and exponent += 1 (mod 256).
    - If sum==0: result = 32'h00000000 (+0) and go to DONE, skipping NORM.
    - Otherwise go to NORM.
  - NORM: each cycle, if man[23]==0, shift left 1 and exponent -= 1 (mod 256); else latch out = {sign, exp, man[22:0]} and go to DONE. Occupancy is k+1 cycles, where k is the leading-zero count.
  - DONE: out_valid=1 and out is held stable until out_ready=1. The handshake edge moves state to IDLE and clears out_valid. out keeps its last value.
- Latency from accept edge to out_valid=1:
  - General case: min(d, SHIFT_CAP) + k + 4 cycles.
  - Zero-sum case: min(d, SHIFT_CAP) + 3 cycles.
  - Bypass case: 1 cycle.
- Throughput: no back-to-back overlap; in_ready rises the cycle after the output handshake.
- Exponent overflow/underflow wraps mod 256 and is not flagged. Inf/NaN/denormal encodings are processed as ordinary normals.

Test Plan:
- Reset: assert rst mid-ALIGN (A=32'h41200000, B=32'h3F800000) -> out_valid=0 and out=0 immediately; after release, in_ready=1 and no stale result appears.
- A=32'h40000000 (2.0), B=32'h3F800000 (1.0) -> out=32'h3F800000 with out_valid 6 cycles after accept (d=1, k=1).
- A=32'h3F800000, B=32'hBF800000 (1-(-1)) -> carry path, out=32'h40000000, latency 4; hold out_ready=0 for 5 cycles -> out stable and in_ready=0 throughout.
- A=B=32'h40400000 (3.0) -> out=32'h00000000, latency 3; A=32'h3F800000, B=32'h4B800000 (d=24) -> mantissa fully shifted out, out=32'hCB800000, latency 28.
- Bypass: A=0, B=32'h40A00000 -> out=32'hC0A00000 after 1 cycle; A=32'hC1000000, B=0 -> out=32'hC1000000.
- Back-to-back: keep in_valid=1 with 3 operand pairs and toggle out_ready randomly -> exactly 3 results in order, each matching its expected value.

Source files
------------

// File: rtl/fp_sub_seq.sv
// Iterative FP32 subtractor: out = inputA - inputB. Truncates, does not round, has no IEEE special cases.
// Latency from accept is min(d,SHIFT_CAP)+k+4 cycles; the zero-sum case takes min(d,SHIFT_CAP)+3; the zero-operand bypass takes 1.
// Backpressure: one operation in flight at a time. out is held in DONE until out_ready; in_ready is high only in IDLE.
// Ports: clk/rst (async active-high); in_valid/in_ready/inputA/inputB operand handshake;
//        out_valid/out_ready/out result handshake.
module fp_sub_seq #(
   parameter int SHIFT_CAP = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] inputA,
   input  logic [31:0] inputB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out
);

   localparam logic [7:0] CAP = 8'(SHIFT_CAP);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t      state, nextState;
   logic [7:0]  cnt;
   logic [23:0] manL, manS, manN;
   logic        signL, signS, signR;
   logic [7:0]  expR;

   // operand prep (only used on the accept edge)
   logic [7:0]  expA, expB, diff, capped;
   logic        signBNeg, aBig, bypassA, bypassB;
   // add stage
   logic [24:0] sum;
   logic        sumSign;

   assign in_ready = (state == IDLE) && !rst;

   always_comb begin
      expA     = inputA[30:23];
      expB     = inputB[30:23];
      signBNeg = ~inputB[31];
      aBig     = (expA >= expB);   // a tie keeps A as the larger operand
      diff     = aBig ? (expA - expB) : (expB - expA);
      capped   = (diff > CAP) ? CAP : diff;
      bypassA  = (inputA == 32'h0);
      bypassB  = (inputB == 32'h0);
   end

   always_comb begin
      sum     = '0;
      sumSign = signL;
      if (signL == signS) begin
         sum     = {1'b0, manL} + {1'b0, manS};
         sumSign = signL;
      end else if (manS < manL) begin
         sum     = {1'b0, manL} - {1'b0, manS};
         sumSign = signL;
      end else begin
         sum     = {1'b0, manS} - {1'b0, manL};
         sumSign = signS;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:  if (in_valid) nextState = (bypassA || bypassB) ? DONE : ALIGN;
         ALIGN: if (cnt == 8'd0) nextState = ADD;
         ADD:   nextState = (sum == 25'd0) ? DONE : NORM;
         NORM:  if (manN[23]) nextState = DONE;
         DONE:  if (out_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         manL      <= '0;
         manS      <= '0;
         manN      <= '0;
         signL     <= 1'b0;
         signS     <= 1'b0;
         signR     <= 1'b0;
         expR      <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               cnt   <= capped;
               manL  <= aBig ? {1'b1, inputA[22:0]} : {1'b1, inputB[22:0]};
               manS  <= aBig ? {1'b1, inputB[22:0]} : {1'b1, inputA[22:0]};
               signL <= aBig ? inputA[31] : signBNeg;
               signS <= aBig ? signBNeg : inputA[31];
               expR  <= aBig ? expA : expB;
               if (bypassA) begin
                  out       <= {signBNeg, inputB[30:0]};
                  out_valid <= 1'b1;
               end else if (bypassB) begin
                  out       <= inputA;
                  out_valid <= 1'b1;
               end
            end
            ALIGN: if (cnt != 8'd0) begin
               manS <= manS >> 1;
               cnt  <= cnt - 8'd1;
            end
            ADD: begin
               signR <= sumSign;
               if (sum == 25'd0) begin
                  out       <= 32'h0;
                  out_valid <= 1'b1;
               end else if (sum[24]) begin
                  // carry out: renormalise right, the dropped LSB is truncated
                  manN <= sum[24:1];
                  expR <= expR + 8'd1;
               end else begin
                  manN <= sum[23:0];
               end
            end
            NORM: begin
               if (!manN[23]) begin
                  manN <= manN << 1;
                  expR <= expR - 8'd1;
               end else begin
                  out       <= {signR, expR, manN[22:0]};
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sub_seq.sv
module tb_fp_sub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] inputA, inputB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;

   int checks = 0;
   int errors = 0;

   fp_sub_seq #(.SHIFT_CAP(24)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .inputA(inputA), .inputB(inputB),
      .out_valid(out_valid), .out_ready(out_ready), .out(out)
   );

   always #5 clk = ~clk;

   // Launches one operation and waits for out_valid, leaving the result un-acknowledged.
   // lat counts clock edges from the accept edge (accept edge = 1); -1 on timeout.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      inputA    = a;
      inputB    = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      inputA   = 32'hDEADBEEF;   // must be ignored after accept
      inputB   = 32'h12345678;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      res = out;
   endtask

   task automatic ack_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got=%h exp=00000000", out); end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_normalise();
      logic [31:0] r; int lat;
      run_op(32'h40000000, 32'h3F800000, r, lat);
      checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL norm_out got=%h exp=3f800000", r); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL norm_latency got=%0d exp=6", lat); end
      ack_op();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
         $display("FAIL norm_handshake got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
   endtask

   task automatic test_carry_stall();
      logic [31:0] r; int lat; int bad;
      run_op(32'h3F800000, 32'hBF800000, r, lat);
      checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL carry_out got=%h exp=40000000", r); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency got=%0d exp=4", lat); end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out !== 32'h40000000 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
      ack_op();
   endtask

   task automatic test_zero_and_cap();
      logic [31:0] r; int lat;
      run_op(32'h40400000, 32'h40400000, r, lat);
      checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL zero_sum_out got=%h exp=00000000", r); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL zero_sum_latency got=%0d exp=3", lat); end
      ack_op();
      run_op(32'h3F800000, 32'h4B800000, r, lat);
      checks++; if (r !== 32'hCB800000) begin errors++; $display("FAIL cap_out got=%h exp=cb800000", r); end
      checks++; if (lat !== 28) begin errors++; $display("FAIL cap_latency got=%0d exp=28", lat); end
      ack_op();
   endtask

   task automatic test_bypass();
      logic [31:0] r; int lat;
      run_op(32'h00000000, 32'h40A00000, r, lat);
      checks++; if (r !== 32'hC0A00000) begin errors++; $display("FAIL bypassA_out got=%h exp=c0a00000", r); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL bypassA_latency got=%0d exp=1", lat); end
      ack_op();
      run_op(32'hC1000000, 32'h00000000, r, lat);
      checks++; if (r !== 32'hC1000000) begin errors++; $display("FAIL bypassB_out got=%h exp=c1000000", r); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL bypassB_latency got=%0d exp=1", lat); end
      ack_op();
      run_op(32'h00000000, 32'h00000000, r, lat);
      checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL bypass00_out got=%h exp=80000000", r); end
      ack_op();
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic [31:0] ve [3];
      int sent, got, cyc;
      logic acc, resp;
      logic [31:0] cap;
      va[0] = 32'h40000000; vb[0] = 32'h3F800000; ve[0] = 32'h3F800000;
      va[1] = 32'h00000000; vb[1] = 32'h40A00000; ve[1] = 32'hC0A00000;
      va[2] = 32'h3F800000; vb[2] = 32'hBF800000; ve[2] = 32'h40000000;
      sent = 0; got = 0; cyc = 0;
      inputA = va[0]; inputB = vb[0]; in_valid = 1'b1;
      out_ready = 1'b0;
      while (got < 3 && cyc < 400) begin
         acc  = in_valid && in_ready;
         resp = out_valid && out_ready;
         cap  = out;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            sent++;
            if (sent < 3) begin inputA = va[sent]; inputB = vb[sent]; end
            else in_valid = 1'b0;
         end
         if (resp) begin
            checks++; if (cap !== ve[got]) begin errors++;
               $display("FAIL b2b_result%0d got=%h exp=%h", got, cap, ve[got]); end
            got++;
         end
         out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++; if (got !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", got); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_result got out_valid=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      inputA = 32'h41200000; inputB = 32'h3F800000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;   // now in ALIGN
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out !== 32'h0) begin errors++; $display("FAIL midrst_out got=%h exp=00000000", out); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL postrst_in_ready got=%b exp=1", in_ready); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL postrst_stale got=%0d valid cycles exp=0", seen); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      inputA = '0; inputB = '0;
      test_reset();
      test_normalise();
      test_carry_stall();
      test_zero_and_cap();
      test_bypass();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
